// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter that funnels NUM_REQ write requesters into one FIFO write port.
// Optional per-requester accept counters are enabled by defining FIFO_WR_ARB_STATS_EN.
module fifo_wr_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          full,
  input  logic                          almostfull,
  input  logic                          wr_ack,
  input  logic                          overflow,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          err_overflow
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         accept_cnt
`endif
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t                state_q, state_d;
  logic [IDW-1:0]        ptr_q, ptr_d;
  logic                  wr_en_q;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IDW-1:0]        gid_q, gid_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQ];
  logic [IDW:0]          cand_sum;
  logic [IDW-1:0]        sel_idx;
  logic                  sel_found;
  logic                  throttle;
  logic                  accept;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign req_data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // With almostfull, the write already on wr_en consumes the last free slot.
  assign throttle = full | (almostfull & wr_en_q);

  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    cand_sum  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand_sum >= (IDW+1)'(NUM_REQ)) begin
        cand_sum = cand_sum - (IDW+1)'(NUM_REQ);
      end
      if (!sel_found && req_valid[cand_sum[IDW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand_sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && !throttle && sel_found) begin
      req_ready[sel_idx] = 1'b1;
    end
  end

  assign accept = |req_ready;

  always_comb begin
    ptr_d  = ptr_q;
    data_d = data_q;
    gid_d  = gid_q;
    if (accept) begin
      ptr_d  = (sel_idx == IDW'(NUM_REQ-1)) ? '0 : sel_idx + IDW'(1);
      data_d = req_data_arr[sel_idx];
      gid_d  = sel_idx;
    end
  end

  // WAIT means a write went out last cycle, so wr_ack/overflow are meaningful now.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_en_q) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (overflow || !wr_ack) err_d = 1'b1;
        if (!wr_en_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      wr_en_q <= 1'b0;
      data_q  <= '0;
      gid_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wr_en_q <= accept;
      data_q  <= data_d;
      gid_q   <= gid_d;
      err_q   <= err_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign data_in      = data_q;
  assign grant_id     = gid_q;
  assign err_overflow = err_q;

`ifdef FIFO_WR_ARB_STATS_EN
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
      logic [15:0] cnt_q;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else if (req_valid[gi] && req_ready[gi]) begin
          cnt_q <= cnt_q + 16'd1;
        end
      end
      assign accept_cnt[gi*16 +: 16] = cnt_q;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb: directed vector table, hand-written corner
// sequences and a randomized run against a behavioural model.
module tb_fifo_wr_arb;

  localparam int N  = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          wr_en;
  logic [DW-1:0] data_in;
  logic          full, almostfull, wr_ack, overflow;
  logic [1:0]    grant_id;
  logic          err_overflow;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [N*16-1:0] accept_cnt;
`endif

  int checks = 0;
  int errors = 0;

  fifo_wr_arb #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .wr_en(wr_en),
    .data_in(data_in),
    .full(full),
    .almostfull(almostfull),
    .wr_ack(wr_ack),
    .overflow(overflow),
    .grant_id(grant_id),
    .err_overflow(err_overflow)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .accept_cnt(accept_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  valid;
    logic [15:0] base;
    logic        full;
    logic        af;
    logic [3:0]  exp_ready;
    logic        exp_wr;
    logic [1:0]  exp_gid;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs [19];

  // behavioural model state
  int          m_ptr;
  logic        m_wr;
  logic [15:0] m_data;
  int          m_gid;
  logic        m_wait;
  logic        m_err;
  logic [15:0] m_cnt [N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_base(input logic [15:0] b);
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = b + 16'(i);
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    int best = -1;
    int bd = N;
    for (int i = 0; i < N; i++) begin
      if (v[i] && ((i - p + N) % N) < bd) begin
        bd = (i - p + N) % N;
        best = i;
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_wr = 0; m_data = '0; m_gid = 0; m_wait = 0; m_err = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = '0;
  endtask

  // Reset applied while every requester is asking; nothing may be granted.
  task automatic do_reset();
    rst_n = 1'b0; req_valid = '1; set_base(16'h7700);
    full = 0; almostfull = 0; wr_ack = 1; overflow = 0;
    #1;
    check("rst_ready", 64'(req_ready), 64'h0);
    @(posedge clk); #1;
    check("rst_wr_en", 64'(wr_en), 64'h0);
    check("rst_data", 64'(data_in), 64'h0);
    check("rst_gid", 64'(grant_id), 64'h0);
    check("rst_err", 64'(err_overflow), 64'h0);
    check("rst_ready2", 64'(req_ready), 64'h0);
`ifdef FIFO_WR_ARB_STATS_EN
    check("rst_cnt", 64'(accept_cnt), 64'h0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    $display("reset applied and released at %0t", $time);
  endtask

  // One cycle against the model: inputs already driven at posedge+1.
  task automatic model_step();
    int sel;
    logic [N-1:0] exp_ready;
    #1;
    sel = pick(req_valid, m_ptr);
    exp_ready = '0;
    if (rst_n && !full && !(almostfull && m_wr) && sel >= 0) exp_ready[sel] = 1'b1;
    check("m_ready", 64'(req_ready), 64'(exp_ready));
    check("m_wr_en", 64'(wr_en), 64'(m_wr));
    check("m_data", 64'(data_in), 64'(m_data));
    check("m_gid", 64'(grant_id), 64'(m_gid));
    check("m_err", 64'(err_overflow), 64'(m_err));
`ifdef FIFO_WR_ARB_STATS_EN
    for (int i = 0; i < N; i++) check("m_cnt", 64'(accept_cnt[i*16 +: 16]), 64'(m_cnt[i]));
`endif
    if (!rst_n) begin
      model_reset();
    end else begin
      if (m_wait && (overflow || !wr_ack)) m_err = 1'b1;
      m_wait = m_wr;
      if (exp_ready != 0) begin
        m_wr   = 1'b1;
        m_data = req_data[sel*DW +: DW];
        m_gid  = sel;
        m_ptr  = (sel + 1) % N;
        m_cnt[sel] = m_cnt[sel] + 16'd1;
      end else begin
        m_wr = 1'b0;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    // valid, base, full, af, exp_ready, exp_wr, exp_gid, exp_data
    vecs[0]  = '{4'b1111, 16'h1000, 1'b0, 1'b0, 4'b0001, 1'b0, 2'd0, 16'h0000};
    vecs[1]  = '{4'b1111, 16'h1100, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd0, 16'h1000};
    vecs[2]  = '{4'b1111, 16'h1200, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd1, 16'h1101};
    vecs[3]  = '{4'b1111, 16'h1300, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd2, 16'h1202};
    vecs[4]  = '{4'b1111, 16'h1400, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd3, 16'h1303};
    vecs[5]  = '{4'b1111, 16'h1500, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd0, 16'h1400};
    vecs[6]  = '{4'b1111, 16'h1600, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd1, 16'h1501};
    vecs[7]  = '{4'b1111, 16'h1700, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd2, 16'h1602};
    vecs[8]  = '{4'b0000, 16'h0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd3, 16'h1703};
    vecs[9]  = '{4'b0100, 16'hA5A3, 1'b0, 1'b0, 4'b0100, 1'b0, 2'd3, 16'h1703};
    vecs[10] = '{4'b0000, 16'h0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 16'hA5A5};
    vecs[11] = '{4'b1111, 16'h2000, 1'b0, 1'b0, 4'b1000, 1'b0, 2'd2, 16'hA5A5};
    vecs[12] = '{4'b1111, 16'h2100, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd3, 16'h2003};
    vecs[13] = '{4'b1111, 16'h2200, 1'b0, 1'b1, 4'b0001, 1'b0, 2'd3, 16'h2003};
    vecs[14] = '{4'b1111, 16'h2300, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd0, 16'h2200};
    vecs[15] = '{4'b1111, 16'h2400, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 16'h2200};
    vecs[16] = '{4'b1111, 16'h2500, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 16'h2200};
    vecs[17] = '{4'b1111, 16'h2600, 1'b0, 1'b0, 4'b0010, 1'b0, 2'd0, 16'h2200};
    vecs[18] = '{4'b0000, 16'h0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1, 16'h2601};

    req_data = '0;
    do_reset();

    for (int r = 0; r < 19; r++) begin
      req_valid = vecs[r].valid; set_base(vecs[r].base);
      full = vecs[r].full; almostfull = vecs[r].af; wr_ack = 1'b1; overflow = 1'b0;
      #1;
      check("vec_ready", 64'(req_ready), 64'(vecs[r].exp_ready));
      check("vec_wr_en", 64'(wr_en), 64'(vecs[r].exp_wr));
      check("vec_gid", 64'(grant_id), 64'(vecs[r].exp_gid));
      check("vec_data", 64'(data_in), 64'(vecs[r].exp_data));
      check("vec_err", 64'(err_overflow), 64'h0);
      $display("vec %0d: valid=%b ready=%b wr_en=%b gid=%0d data=%h",
               r, req_valid, req_ready, wr_en, grant_id, data_in);
      @(posedge clk); #1;
    end

    // Overflow response makes err_overflow sticky until reset.
    req_valid = 4'b0001; wr_ack = 1; overflow = 0;
    @(posedge clk); #1;
    req_valid = 4'b0000;
    check("ovf_wr_en", 64'(wr_en), 64'h1);
    @(posedge clk); #1;
    overflow = 1; wr_ack = 0;
    check("ovf_err_before", 64'(err_overflow), 64'h0);
    @(posedge clk); #1;
    overflow = 0; wr_ack = 1; req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("ovf_sticky", 64'(err_overflow), 64'h1);
      check("ovf_arb_runs", 64'($countones(req_ready)), 64'h1);
      @(posedge clk); #1;
    end
    $display("overflow sequence: err_overflow=%b", err_overflow);

    // Reset during back-to-back traffic, then first grant goes to lowest valid index.
    do_reset();
    req_valid = 4'b1010; set_base(16'h3000);
    #1;
    check("post_rst_ready", 64'(req_ready), 64'b0010);
    @(posedge clk); #1;
    check("post_rst_wr_en", 64'(wr_en), 64'h1);
    check("post_rst_gid", 64'(grant_id), 64'h1);
    check("post_rst_data", 64'(data_in), 64'h3001);
    $display("post-reset grant: gid=%0d data=%h", grant_id, data_in);

    // Randomized run against the behavioural model.
    do_reset();
    model_reset();
    for (int c = 0; c < 2000; c++) begin
      rst_n      = ($urandom_range(99) != 0);
      req_valid  = N'($urandom);
      req_data   = {$urandom, $urandom};
      full       = ($urandom_range(7) == 0);
      almostfull = ($urandom_range(3) == 0);
      wr_ack     = ($urandom_range(19) != 0);
      overflow   = ($urandom_range(29) == 0);
      model_step();
    end
    rst_n = 1'b1;
    $display("random run done: %0d checks so far", checks);

`ifdef FIFO_WR_ARB_STATS_EN
    // Counter wrap: 65537 accepts from requester 1.
    do_reset();
    req_valid = 4'b0010;
    repeat (65537) @(posedge clk);
    #1;
    check("cnt_wrap", 64'(accept_cnt), 64'h0000_0000_0001_0000);
    $display("counter wrap: accept_cnt=%h", accept_cnt);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of write requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, width of the FIFO write data.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester write request.
REQ-006 SHALL have port req_data  input  NUM_REQ*DATA_WIDTH  per-requester data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port req_ready  output  NUM_REQ  per-requester accept, combinational.
REQ-008 SHALL have port wr_en  output  1  FIFO write enable, registered.
REQ-009 SHALL have port data_in  output  DATA_WIDTH  FIFO write data, registered.
REQ-010 SHALL have ports full and almostfull  input  1 each  FIFO status.
REQ-011 SHALL have ports wr_ack and overflow  input  1 each  FIFO write response, valid the cycle after wr_en.
REQ-012 SHALL have port grant_id  output  $clog2(NUM_REQ)  index of the requester whose beat is driven on wr_en, registered.
REQ-013 SHALL have port err_overflow  output  1  sticky error flag.

Function
REQ-014 SHALL accept a beat from requester i when req_valid[i] and req_ready[i] are both high at a rising edge.
REQ-015 SHALL assert at most one req_ready bit per cycle (one-hot or zero).
REQ-016 SHALL select the granted requester round-robin: first valid requester at or after pointer ptr, wrapping NUM_REQ-1 -> 0.
REQ-017 SHALL set ptr to (i+1) mod NUM_REQ after an accept from i, and leave ptr unchanged when nothing is accepted.
REQ-018 SHALL hold all req_ready low when full=1, or when almostfull=1 and wr_en=1 (last slot already claimed).
REQ-019 SHALL drive wr_en=1, data_in=req_data[i] and grant_id=i exactly one cycle after an accept from i; otherwise wr_en=0 and data_in/grant_id hold.
REQ-020 SHALL sustain one accept per cycle (back-to-back writes) while the throttle of REQ-018 is not active.
REQ-021 SHALL track one outstanding response: FSM states IDLE (no write in flight) and WAIT (wr_en issued last cycle); IDLE->WAIT on wr_en=1, WAIT->WAIT on wr_en=1, WAIT->IDLE on wr_en=0.
REQ-022 SHALL set err_overflow when overflow=1 in WAIT, or when wr_ack=0 and overflow=0 in WAIT; err_overflow clears only on reset.
REQ-023 SHALL ignore wr_ack and overflow in IDLE.
REQ-024 SHALL not alter req_ready because of err_overflow; arbitration continues.

Reset
REQ-025 SHALL, on rst_n=0 at a rising edge, set wr_en=0, data_in=0, grant_id=0, ptr=0, state=IDLE and err_overflow=0.
REQ-026 SHALL hold req_ready all-zero while rst_n=0; a beat in flight when reset asserts SHALL be dropped with no wr_en issued.

Configuration
REQ-027 SHALL, with macro FIFO_WR_ARB_STATS_EN defined, add output accept_cnt (NUM_REQ*16 bits, 16 bits per requester, same slicing as req_data), incremented on each accept, wrapping 0xFFFF -> 0x0000, reset to 0.
REQ-028 SHALL, without FIFO_WR_ARB_STATS_EN, omit the accept_cnt port and its counters entirely; all other behaviour SHALL be identical.

Verification
REQ-029 SHALL cover: req_valid=4'b1111 for 8 cycles, FIFO not full -> grant_id sequence 0,1,2,3,0,1,2,3, wr_en high 8 consecutive cycles.
REQ-030 SHALL cover: only req_valid[2]=1 with data 16'hA5A5 -> req_ready=4'b0100 the same cycle, wr_en=1 and data_in=16'hA5A5 one cycle later, ptr=3.
REQ-031 SHALL cover: almostfull=1 while wr_en=1 -> req_ready=4'b0000 that cycle; full=1 for 3 cycles -> no wr_en for those cycles plus one cycle.
REQ-032 SHALL cover: wr_en issued, overflow=1 the next cycle -> err_overflow=1 and it stays 1 until rst_n=0.
REQ-033 SHALL cover: rst_n=0 during back-to-back traffic -> the next cycle wr_en=0, grant_id=0, and after release the first grant goes to the lowest valid index.
REQ-034 SHALL cover, with FIFO_WR_ARB_STATS_EN: 65537 accepts from requester 1 -> accept_cnt[31:16]=16'h0001, other slices 0.
